btn_event_reporter: RTL and testbench
=====================================

// Module: btn_event_reporter
// PURPOSE
//  Upstream feeder for the hex-over-UART transmitter. Synchronizes and debounces a raw
//  push-button, counts raw edges (bounces) and clean presses, and on every clean press
//  issues one 32-bit report word over a stb/busy handshake to the transmitter.
//  Sits between the board button pin and the transmitter's i_stb/i_data/o_busy.
// PARAMETERS
//  DEBOUNCE_CYCLES  100000  cycles the synchronized input must stay stable before o_debounced follows (>=2)
//  CW               16      width of each event counter; report packs two of them (2*CW must equal 32)
// PORTS
//  i_clk        in   1   system clock; all state on rising edge
//  i_reset_n    in   1   asynchronous, active-low reset
//  i_btn        in   1   raw, asynchronous, bouncing button level
//  i_busy       in   1   downstream busy (transmitter o_busy); word accepted on o_stb && !i_busy
//  o_stb        out  1   report valid; held until accepted
//  o_data       out  32  report {press_count[CW-1:0], bounce_count[CW-1:0]}; stable while o_stb
//  o_debounced  out  1   debounced button level
//  o_dropped    out  1   sticky: a press arrived while one was already pending
// BEHAVIOUR
//  Reset: one clock; asynchronous, active-low reset (i_reset_n). Assertion clears
//   immediately: sync FFs=0, o_debounced=0, timer=0, counters=0, o_stb=0, o_data=0,
//   pending=0, o_dropped=0. Reset mid-handshake abandons the word; no retransmit.
//  Sync: 2-FF synchronizer on i_btn -> s_btn (2-cycle latency); nothing else samples i_btn.
//  Bounce counter: +1 each cycle s_btn != previous s_btn; wraps at 2^CW.
//  Debounce (sub-module): any s_btn change reloads timer to DEBOUNCE_CYCLES-1.
//   Else if timer!=0, decrement. When timer==0 and s_btn!=o_debounced, o_debounced<=s_btn.
//   A level held exactly DEBOUNCE_CYCLES cycles after its last edge is adopted the next cycle.
//   Glitches shorter than DEBOUNCE_CYCLES never reach o_debounced.
//  Press event: rising edge of o_debounced (registered copy 0, current 1); press counter
//   +1, wraps at 2^CW. Falling edges are not reported.
//  Reporter FSM, states IDLE, REQ:
//   IDLE: on press event -> REQ, o_stb<=1, o_data<={press_count+1, bounce_count} (the
//    values including this event).
//   REQ: o_stb=1, o_data frozen. If !i_busy: accepted this cycle; next cycle ->
//    IDLE (o_stb=0) unless pending, in which case stay REQ with a fresh snapshot, pending<=0.
//   Press event while REQ: pending<=1; if pending already 1, o_dropped<=1 (at most one queued).
//   Press event in the same cycle as acceptance: counts as pending (re-issue next cycle).
//  Minimum gap: o_stb deasserts >=1 cycle between words unless pending, so the transmitter
//   always sees a clean strobe edge. Counters never stall; o_dropped only clears on reset.
// STRUCTURE
//  Package btn_report_pkg: CW, report field offsets (PRESS_LSB=16, BOUNCE_LSB=0),
//   reporter state encoding (IDLE=1'b0, REQ=1'b1).
//  Sub-module debouncer (params DEBOUNCE_CYCLES; ports i_clk, i_reset_n, i_sync, o_level);
//   synchronizer, counters and reporter FSM stay in this file.
// TESTING  (DEBOUNCE_CYCLES=4 in the bench)
//  1 Reset: hold i_reset_n=0 with i_btn=1 -> o_stb=0, o_data=0, o_debounced=0 throughout.
//  2 Clean press: i_btn 0->1 held 20 cycles, i_busy=0 -> o_debounced rises 7 cycles after edge;
//    one o_stb pulse, o_data=32'h0001_0001.
//  3 Bouncy press: i_btn toggles 1,0,1,0,1 each 1 cycle then holds 1 -> bounce_count=5,
//    single report 32'h0001_0005; no intermediate o_debounced change.
//  4 Backpressure: i_busy=1 for 50 cycles during press -> o_stb held, o_data constant;
//    i_busy->0 -> accepted; o_stb low next cycle.
//  5 Queue/drop: three presses while i_busy=1 -> o_dropped=1; after release two words
//    (press 1, then snapshot with press 3).
//  6 Async reset during REQ: drop i_reset_n mid-cycle -> o_stb=0 before next edge; counters 0.

Source files
------------

// File: rtl/btn_report_pkg.sv
// Shared constants for the button event reporter:
// counter width, report field offsets and reporter state encoding.
package btn_report_pkg;

    localparam int CW         = 16;
    localparam int PRESS_LSB  = 16;
    localparam int BOUNCE_LSB = 0;

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] REQ  = 1'b1;

endpackage

// File: rtl/debouncer.sv
// Stability filter: the output follows the input only after it has
// held one level for DEBOUNCE_CYCLES cycles since its last edge.
module debouncer #(
    parameter int DEBOUNCE_CYCLES = 100000
) (
    input  logic i_clk,
    input  logic i_reset_n,
    input  logic i_sync,
    output logic o_level
);

    localparam int TW = $clog2(DEBOUNCE_CYCLES);
    localparam logic [TW-1:0] RELOAD = TW'(DEBOUNCE_CYCLES - 1);

    logic [TW-1:0] timer;
    logic          prev;

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            timer   <= '0;
            prev    <= 1'b0;
            o_level <= 1'b0;
        end else begin
            prev <= i_sync;
            if (i_sync != prev) begin
                timer <= RELOAD;
            end else if (timer != '0) begin
                timer <= timer - TW'(1);
            end else if (i_sync != o_level) begin
                o_level <= i_sync;
            end
        end
    end

endmodule

// File: rtl/btn_event_reporter.sv
// Button front end: synchronize, debounce, count bounces and presses,
// and hand one report word per clean press to the UART transmitter.
module btn_event_reporter #(
    parameter int DEBOUNCE_CYCLES = 100000,
    parameter int CW              = btn_report_pkg::CW
) (
    input  logic        i_clk,
    input  logic        i_reset_n,
    input  logic        i_btn,
    input  logic        i_busy,
    output logic        o_stb,
    output logic [31:0] o_data,
    output logic        o_debounced,
    output logic        o_dropped
);

    import btn_report_pkg::*;

    logic          sync1;
    logic          s_btn;
    logic          s_prev;
    logic          deb_q;
    logic          pending;
    logic [0:0]    state;
    logic [CW-1:0] press_cnt;
    logic [CW-1:0] bounce_cnt;
    logic [CW-1:0] press_next;
    logic          press;
    logic          bounce_edge;
    logic          accept;
    logic [31:0]   snap;

    debouncer #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_debouncer (
        .i_clk    (i_clk),
        .i_reset_n(i_reset_n),
        .i_sync   (s_btn),
        .o_level  (o_debounced)
    );

    assign press       = o_debounced & ~deb_q;
    assign bounce_edge = s_btn ^ s_prev;
    assign accept      = o_stb & ~i_busy;
    assign press_next  = press_cnt + CW'(press);

    // Snapshot includes the press being reported this cycle.
    always_comb begin
        snap = '0;
        snap[PRESS_LSB +: CW]  = press_next;
        snap[BOUNCE_LSB +: CW] = bounce_cnt;
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            sync1      <= 1'b0;
            s_btn      <= 1'b0;
            s_prev     <= 1'b0;
            deb_q      <= 1'b0;
            press_cnt  <= '0;
            bounce_cnt <= '0;
            state      <= IDLE;
            o_stb      <= 1'b0;
            o_data     <= '0;
            pending    <= 1'b0;
            o_dropped  <= 1'b0;
        end else begin
            sync1      <= i_btn;
            s_btn      <= sync1;
            s_prev     <= s_btn;
            deb_q      <= o_debounced;
            press_cnt  <= press_next;
            bounce_cnt <= bounce_cnt + CW'(bounce_edge);
            case (state)
                IDLE: begin
                    if (press) begin
                        state  <= REQ;
                        o_stb  <= 1'b1;
                        o_data <= snap;
                    end
                end
                REQ: begin
                    if (press && pending) begin
                        o_dropped <= 1'b1;
                    end
                    if (accept) begin
                        if (pending || press) begin
                            o_data  <= snap;
                            pending <= 1'b0;
                        end else begin
                            state <= IDLE;
                            o_stb <= 1'b0;
                        end
                    end else if (press) begin
                        pending <= 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                    o_stb <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_btn_event_reporter.sv
// Directed and randomized bench for btn_event_reporter against a
// window-based behavioural model of debounce, counting and reporting.
module tb_btn_event_reporter;

    localparam int DC = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        btn = 1'b1;
    logic        busy = 1'b0;
    logic        stb;
    logic [31:0] data;
    logic        deb;
    logic        drop;

    int errors = 0;
    int checks = 0;

    logic [31:0] got[$];

    logic        h[0:DC+1];
    logic        m_deb;
    logic        m_deb_old;
    logic [15:0] m_press;
    logic [15:0] m_bounce;
    logic        m_stb;
    logic        m_pend;
    logic        m_drop;
    logic [31:0] m_data;

    always #5 clk = ~clk;

    btn_event_reporter #(
        .DEBOUNCE_CYCLES(DC),
        .CW             (16)
    ) dut (
        .i_clk      (clk),
        .i_reset_n  (rst_n),
        .i_btn      (btn),
        .i_busy     (busy),
        .o_stb      (stb),
        .o_data     (data),
        .o_debounced(deb),
        .o_dropped  (drop)
    );

    task automatic chk(input string tag, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        assert (act === exp) else begin
            errors++;
            $error("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i <= DC + 1; i++) h[i] = 1'b0;
        m_deb     = 1'b0;
        m_deb_old = 1'b0;
        m_press   = '0;
        m_bounce  = '0;
        m_stb     = 1'b0;
        m_pend    = 1'b0;
        m_drop    = 1'b0;
        m_data    = '0;
    endtask

    // h[0] is the button sampled at the previous edge; the synchronized
    // level seen by the debouncer lags it by one more sample.
    task automatic model_edge();
        logic        p;
        logic        inc;
        logic        win;
        logic        nd;
        logic [15:0] pn;
        p   = m_deb && !m_deb_old;
        inc = (h[1] != h[2]);
        win = 1'b1;
        for (int i = 2; i <= DC + 1; i++) if (h[i] != h[1]) win = 1'b0;
        nd  = win ? h[1] : m_deb;
        pn  = m_press + 16'(p);
        if (!m_stb) begin
            if (p) begin
                m_stb  = 1'b1;
                m_data = {pn, m_bounce};
            end
        end else begin
            if (p && m_pend) m_drop = 1'b1;
            if (!busy) begin
                if (m_pend || p) begin
                    m_data = {pn, m_bounce};
                    m_pend = 1'b0;
                end else begin
                    m_stb = 1'b0;
                end
            end else if (p) begin
                m_pend = 1'b1;
            end
        end
        m_press   = pn;
        m_bounce  = m_bounce + 16'(inc);
        m_deb_old = m_deb;
        m_deb     = nd;
        for (int i = DC + 1; i > 0; i--) h[i] = h[i-1];
        h[0] = btn;
    endtask

    task automatic tick();
        if (stb && !busy) got.push_back(data);
        @(posedge clk);
        model_edge();
        @(negedge clk);
        chk("stb", 32'(stb), 32'(m_stb));
        chk("data", data, m_data);
        chk("debounced", 32'(deb), 32'(m_deb));
        chk("dropped", 32'(drop), 32'(m_drop));
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        btn   = 1'b0;
        busy  = 1'b0;
        @(negedge clk);
        chk("rst_stb", 32'(stb), 32'd0);
        rst_n = 1'b1;
        model_reset();
        got.delete();
    endtask

    initial begin
        int          rise;
        int          dchg;
        int          stable;
        int          len;
        logic        first;
        logic        pd;
        logic [31:0] held;
        logic        pat[5];

        model_reset();
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("reset_stb", 32'(stb), 32'd0);
            chk("reset_data", data, 32'd0);
            chk("reset_deb", 32'(deb), 32'd0);
        end
        btn   = 1'b0;
        rst_n = 1'b1;

        // clean press
        btn  = 1'b1;
        rise = 0;
        for (int i = 1; i <= 20; i++) begin
            tick();
            if (deb && rise == 0) rise = i;
        end
        chk("clean_rise", 32'(rise), 32'd7);
        chk("clean_count", 32'(got.size()), 32'd1);
        chk("clean_word", got.size() > 0 ? got[0] : 'x, 32'h0001_0001);
        btn = 1'b0;
        repeat (20) tick();

        // bouncy press
        do_reset();
        pat  = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
        dchg = 0;
        for (int i = 0; i < 25; i++) begin
            btn = (i < 5) ? pat[i] : 1'b1;
            pd  = deb;
            tick();
            if (deb != pd) dchg++;
        end
        chk("bouncy_deb_changes", 32'(dchg), 32'd1);
        chk("bouncy_count", 32'(got.size()), 32'd1);
        chk("bouncy_word", got.size() > 0 ? got[0] : 'x, 32'h0001_0005);

        // backpressure
        do_reset();
        busy   = 1'b1;
        btn    = 1'b1;
        first  = 1'b1;
        stable = 1;
        held   = '0;
        repeat (50) begin
            tick();
            if (stb) begin
                if (first) begin
                    held  = data;
                    first = 1'b0;
                end else if (data !== held) begin
                    stable = 0;
                end
            end
        end
        chk("bp_stb_held", 32'(stb), 32'd1);
        chk("bp_data_stable", 32'(stable), 32'd1);
        busy = 1'b0;
        tick();
        chk("bp_accept_count", 32'(got.size()), 32'd1);
        chk("bp_word", got.size() > 0 ? got[0] : 'x, 32'h0001_0001);
        chk("bp_gap", 32'(stb), 32'd0);

        // queue and drop
        do_reset();
        busy = 1'b1;
        repeat (3) begin
            btn = 1'b1;
            repeat (10) tick();
            btn = 1'b0;
            repeat (10) tick();
        end
        chk("q_dropped", 32'(drop), 32'd1);
        busy = 1'b0;
        repeat (10) tick();
        chk("q_count", 32'(got.size()), 32'd2);
        chk("q_word1", got.size() > 0 ? got[0] : 'x, 32'h0001_0001);
        chk("q_word2", got.size() > 1 ? got[1] : 'x, 32'h0003_0006);
        chk("q_dropped_sticky", 32'(drop), 32'd1);

        // asynchronous reset while a word is pending
        do_reset();
        busy = 1'b1;
        btn  = 1'b1;
        repeat (12) tick();
        chk("ar_stb_before", 32'(stb), 32'd1);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("ar_stb", 32'(stb), 32'd0);
        chk("ar_data", data, 32'd0);
        chk("ar_deb", 32'(deb), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        got.delete();
        busy = 1'b0;
        repeat (12) tick();
        chk("ar_restart_count", 32'(got.size()), 32'd1);
        chk("ar_restart_word", got.size() > 0 ? got[0] : 'x, 32'h0001_0001);

        // randomized traffic against the model
        do_reset();
        for (int s = 0; s < 150; s++) begin
            btn = 1'($urandom_range(0, 1));
            len = int'($urandom_range(1, 9));
            for (int c = 0; c < len; c++) begin
                busy = 1'($urandom_range(0, 1));
                tick();
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
